motion_centroid: RTL and testbench
==================================

// Module: motion_centroid
// PURPOSE
//  Consumes the 8-bit grayscale raster stream of the image front end (160x148, one pixel per pix_valid).
//  Compares each pixel with the same pixel of the previous frame, held in an internal frame buffer.
//  Marks pixels whose absolute difference exceeds THRESH as motion.
//  Reports per-frame motion count and truncated centroid (x,y), which the speed-estimation stage tracks.
// PARAMETERS
//  IMG_W      160  pixels per line
//  IMG_H      148  lines per frame
//  THRESH     30   motion if |cur-prev| > THRESH (strict)
//  MIN_COUNT  1    fewer motion pixels than this -> motion_detected=0, centroid forced 0
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high
//  pix_valid        in   1   pix_gray valid this cycle; gaps allowed
//  pix_gray         in   8   grayscale pixel, raster order
//  frame_start      in   1   qualified by pix_valid; marks pixel (0,0) and resyncs counters
//  result_valid     out  1   one-cycle pulse: result outputs updated
//  motion_detected  out  1   count >= MIN_COUNT
//  motion_count     out  15  motion pixels in frame (max 23680)
//  cent_x           out  8   sum_x/count, truncated (0..159)
//  cent_y           out  8   sum_y/count, truncated (0..147)
//  busy             out  1   divider running
//  overrun          out  1   one-cycle pulse: new frame end while divider busy
// BEHAVIOUR
//  Reset: all outputs 0; x=y=0; accumulators 0; prime=1; divider idle.
//  Raster: each accepted pixel advances x; x=IMG_W-1 -> x=0, y++.
//    Frame end = accepted pixel (IMG_W-1, IMG_H-1); x,y then return to 0.
//  Pipeline stage 0 (accept cycle N): frame buffer read at addr y*IMG_W+x; pixel, x, y registered.
//  Stage 1 (N+1):
//    d = |cur-prev| (unsigned, both directions).
//    If d>THRESH and !prime: count++, sum_x+=x, sum_y+=y.
//    cur written back to the same addr.
//  Accumulators: sum_x 22b, sum_y 22b, count 15b; no overflow possible at max frame.
//  Frame end at stage 1:
//    If prime: clear prime, clear accumulators, no result.
//    Else: snapshot {sum_x,sum_y,count} into divider regs, clear accumulators same cycle.
//      Next frame accumulates in parallel.
//  Divider FSM IDLE->DIV->DONE->IDLE:
//    DIV: 22 iterations restoring division, x and y in parallel against count.
//    DONE: register outputs, pulse result_valid.
//  Latency: result_valid exactly 24 cycles after the accept cycle of the last pixel (independent of count).
//  count < MIN_COUNT: divider still runs (constant latency); cent_x=cent_y=0, motion_detected=0, motion_count=true count.
//  Frame end while DIV: overrun pulses, divider restarts on new snapshot, old result dropped.
//  frame_start with pix_valid: pixel taken as (0,0); accumulators cleared; prime=1.
//    Partial frame discarded; the following frame only reloads buffer; reporting resumes the frame after.
//  frame_start on pixel already computed as (0,0): no effect.
//  Reset mid-operation: divider aborted, no result_valid, prime=1; buffer contents irrelevant (prime).
//  Outputs hold between result_valid pulses.
// STRUCTURE
//  img_pkg: IMG_W, IMG_H, PIX_W=8, ADDR_W=15, SUM_W=22, CNT_W=15.
//    Shared with the image front end.
//  Sub-module frame_buffer: simple dual-port RAM, IMG_W*IMG_H x 8, 1-cycle registered read.
//    Read/write on independent ports; no same-address conflict by construction.
//  Divider and FSM stay inline.
// TESTING
//  1 Reset; two frames all 100 -> frame 1 no result_valid.
//    Frame 2: result_valid, count=0, detected=0, cent=(0,0).
//  2 Frame all 0, then frame with 200 at x40..49, y20..29 -> count=100, cent=(44,24), detected=1.
//    result_valid exactly 24 cycles after last pixel.
//  3 Frame all 0, then (0,0)=30 and (159,147)=31 -> count=1, cent=(159,147): d=THRESH not motion.
//  4 Repeat test 2 with random 50% pix_valid gaps -> identical results.
//    Also 200->0 reversal gives count=100.
//  5 frame_start at pixel 5000 -> that frame and next give no result; third frame reports correctly.
//  6 reset asserted 10 cycles into DIV -> no result_valid, outputs 0.
//    Next frame primes only; the one after reports.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: raster geometry, data widths, motion
// threshold and the divider state encoding.
package img_pkg;

    localparam int IMG_W     = 160;
    localparam int IMG_H     = 148;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 15;
    localparam int SUM_W     = 22;
    localparam int CNT_W     = 15;
    localparam int COORD_W   = 8;
    localparam int THRESH    = 30;
    localparam int MIN_COUNT = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Unsigned absolute difference, whichever pixel is brighter.
    function automatic logic [PIX_W-1:0] absDiff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/motion_centroid_if.sv
// Pixel stream in / per-frame motion result out. The master side is the
// image front end, the slave side is the motion_centroid block.
interface motion_centroid_if;
    import img_pkg::*;

    logic               pix_valid;
    logic [PIX_W-1:0]   pix_gray;
    logic               frame_start;
    logic               result_valid;
    logic               motion_detected;
    logic [CNT_W-1:0]   motion_count;
    logic [COORD_W-1:0] cent_x;
    logic [COORD_W-1:0] cent_y;
    logic               busy;
    logic               overrun;

    modport master (
        output pix_valid, pix_gray, frame_start,
        input  result_valid, motion_detected, motion_count, cent_x, cent_y,
               busy, overrun
    );

    modport slave (
        input  pix_valid, pix_gray, frame_start,
        output result_valid, motion_detected, motion_count, cent_x, cent_y,
               busy, overrun
    );

endinterface

// File: rtl/frame_buffer.sv
// Simple dual-port frame store holding the previous frame, one-cycle
// registered read. Writer and reader never target the same address in the
// same cycle, so no bypass is needed.
module frame_buffer #(
    parameter int DEPTH  = 23680,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdData;

    // Write port: current pixel replaces the stored one.
    always_ff @(posedge clk) begin
        if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    end

    // Read port: previous-frame pixel available the cycle after the request.
    always_ff @(posedge clk) begin
        if (i_rdEn) r_rdData <= r_mem[i_rdAddr];
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/motion_centroid.sv
// Frame-difference motion detector: counts pixels that changed by more than
// THRESH since the previous frame and reports the truncated centroid of the
// changed pixels once per frame, via a 22-step restoring divider.
module motion_centroid
    import img_pkg::*;
#(
    parameter int P_IMG_W = IMG_W,
    parameter int P_IMG_H = IMG_H
) (
    input  logic             clk,
    input  logic             reset,
    motion_centroid_if.slave bus
);

    localparam int                 L_DEPTH     = P_IMG_W * P_IMG_H;
    localparam int                 L_ADDR_W    = $clog2(L_DEPTH);
    localparam logic [COORD_W-1:0] L_LAST_X    = COORD_W'(P_IMG_W - 1);
    localparam logic [COORD_W-1:0] L_LAST_Y    = COORD_W'(P_IMG_H - 1);
    localparam logic [4:0]         L_LAST_ITER = 5'(SUM_W - 1);

    logic [COORD_W-1:0]  r_x, r_y, w_posX, w_posY, r_s1X, r_s1Y;
    logic                w_atOrigin, w_sync, w_lastPix;
    logic [L_ADDR_W-1:0] w_rdAddr, r_s1Addr;
    logic                r_s1Valid, r_s1Sync, r_s1Last;
    logic [PIX_W-1:0]    r_s1Pix, w_prevPix, w_diff;
    logic                r_prime, w_primeEff, w_motion, w_frameEnd, w_snap;
    logic [SUM_W-1:0]    r_sumX, r_sumY, w_sumXNext, w_sumYNext;
    logic [CNT_W-1:0]    r_cnt, w_cntNext;
    div_state_t          r_state, w_nextState;
    logic [4:0]          r_iter;
    logic [CNT_W-1:0]    r_divisor, r_remX, r_remY;
    logic [SUM_W-1:0]    r_qx, r_qy;
    logic [CNT_W:0]      w_shX, w_shY;
    logic                w_geX, w_geY, w_enough;
    logic                r_resultValid, r_detected, r_overrun;
    logic [CNT_W-1:0]    r_count;
    logic [COORD_W-1:0]  r_centX, r_centY;

    // A frame_start away from the origin relabels this pixel as (0,0) and
    // restarts the frame; at the origin it changes nothing.
    assign w_atOrigin = (r_x == '0) && (r_y == '0);
    assign w_posX     = bus.frame_start ? '0 : r_x;
    assign w_posY     = bus.frame_start ? '0 : r_y;
    assign w_sync     = bus.pix_valid && bus.frame_start && !w_atOrigin;
    assign w_lastPix  = (w_posX == L_LAST_X) && (w_posY == L_LAST_Y);
    assign w_rdAddr   = L_ADDR_W'(w_posY) * L_ADDR_W'(P_IMG_W) + L_ADDR_W'(w_posX);

    // Stage 0: raster counters and the registered copy of the accepted pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_s1Valid <= 1'b0;
            r_s1Sync  <= 1'b0;
            r_s1Last  <= 1'b0;
            r_s1Pix   <= '0;
            r_s1X     <= '0;
            r_s1Y     <= '0;
            r_s1Addr  <= '0;
        end else begin
            r_s1Valid <= bus.pix_valid;
            if (bus.pix_valid) begin
                r_s1Sync <= w_sync;
                r_s1Last <= w_lastPix;
                r_s1Pix  <= bus.pix_gray;
                r_s1X    <= w_posX;
                r_s1Y    <= w_posY;
                r_s1Addr <= w_rdAddr;
                if (w_posX == L_LAST_X) begin
                    r_x <= '0;
                    r_y <= w_lastPix ? '0 : w_posY + 1'b1;
                end else begin
                    r_x <= w_posX + 1'b1;
                    r_y <= w_posY;
                end
            end
        end
    end

    frame_buffer #(
        .DEPTH  (L_DEPTH),
        .ADDR_W (L_ADDR_W),
        .DATA_W (PIX_W)
    ) u_frameBuffer (
        .clk      (clk),
        .i_wrEn   (r_s1Valid),
        .i_wrAddr (r_s1Addr),
        .i_wrData (r_s1Pix),
        .i_rdEn   (bus.pix_valid),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_prevPix)
    );

    // Stage 1: motion decision. The resync pixel belongs to a priming frame.
    assign w_diff     = absDiff(r_s1Pix, w_prevPix);
    assign w_primeEff = r_prime || r_s1Sync;
    assign w_motion   = r_s1Valid && !w_primeEff && (w_diff > PIX_W'(THRESH));
    assign w_sumXNext = r_sumX + (w_motion ? SUM_W'(r_s1X) : '0);
    assign w_sumYNext = r_sumY + (w_motion ? SUM_W'(r_s1Y) : '0);
    assign w_cntNext  = r_cnt + (w_motion ? CNT_W'(1) : '0);
    assign w_frameEnd = r_s1Valid && r_s1Last;
    assign w_snap     = w_frameEnd && !w_primeEff;

    // Stage 1: accumulate, restart on frame end or resync, manage priming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sumX  <= '0;
            r_sumY  <= '0;
            r_cnt   <= '0;
            r_prime <= 1'b1;
        end else if (r_s1Valid) begin
            if (w_frameEnd || r_s1Sync) begin
                r_sumX <= '0;
                r_sumY <= '0;
                r_cnt  <= '0;
            end else begin
                r_sumX <= w_sumXNext;
                r_sumY <= w_sumYNext;
                r_cnt  <= w_cntNext;
            end
            if (w_frameEnd)    r_prime <= 1'b0;
            else if (r_s1Sync) r_prime <= 1'b1;
        end
    end

    // Restoring-division step for x and y against the shared count.
    assign w_shX = {r_remX, r_qx[SUM_W-1]};
    assign w_shY = {r_remY, r_qy[SUM_W-1]};
    assign w_geX = w_shX >= {1'b0, r_divisor};
    assign w_geY = w_shY >= {1'b0, r_divisor};

    // Divider datapath: load the frame snapshot, then one quotient bit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_qx      <= '0;
            r_qy      <= '0;
            r_divisor <= '0;
            r_remX    <= '0;
            r_remY    <= '0;
            r_iter    <= '0;
        end else if (w_snap) begin
            r_qx      <= w_sumXNext;
            r_qy      <= w_sumYNext;
            r_divisor <= w_cntNext;
            r_remX    <= '0;
            r_remY    <= '0;
            r_iter    <= '0;
        end else if (r_state == S_DIV) begin
            r_remX <= w_geX ? CNT_W'(w_shX - {1'b0, r_divisor}) : w_shX[CNT_W-1:0];
            r_remY <= w_geY ? CNT_W'(w_shY - {1'b0, r_divisor}) : w_shY[CNT_W-1:0];
            r_qx   <= {r_qx[SUM_W-2:0], w_geX};
            r_qy   <= {r_qy[SUM_W-2:0], w_geY};
            r_iter <= r_iter + 1'b1;
        end
    end

    // Divider FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    // Divider FSM next state; a fresh snapshot always restarts the division.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (w_snap) w_nextState = S_DIV;
            S_DIV: begin
                if (w_snap)                     w_nextState = S_DIV;
                else if (r_iter == L_LAST_ITER) w_nextState = S_DONE;
            end
            S_DONE:  w_nextState = w_snap ? S_DIV : S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_enough = r_divisor >= CNT_W'(MIN_COUNT);

    // Result registers: updated only in DONE, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resultValid <= 1'b0;
            r_overrun     <= 1'b0;
            r_detected    <= 1'b0;
            r_count       <= '0;
            r_centX       <= '0;
            r_centY       <= '0;
        end else begin
            r_resultValid <= (r_state == S_DONE);
            r_overrun     <= w_snap && (r_state == S_DIV);
            if (r_state == S_DONE) begin
                r_detected <= w_enough;
                r_count    <= r_divisor;
                r_centX    <= w_enough ? r_qx[COORD_W-1:0] : '0;
                r_centY    <= w_enough ? r_qy[COORD_W-1:0] : '0;
            end
        end
    end

    assign bus.result_valid    = r_resultValid;
    assign bus.motion_detected = r_detected;
    assign bus.motion_count    = r_count;
    assign bus.cent_x          = r_centX;
    assign bus.cent_y          = r_centY;
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.overrun         = r_overrun;

endmodule

// File: tb/tb_motion_centroid.sv
// Scoreboard bench for motion_centroid on a reduced 64x40 raster: each frame
// pushes its hand-computed result before streaming, a negedge monitor pops
// and compares on every result_valid.
module tb_motion_centroid;

    localparam int W    = 64;
    localparam int H    = 40;
    localparam int NPIX = W * H;

    localparam int PAT_100    = 0;
    localparam int PAT_0      = 1;
    localparam int PAT_BOX    = 2;
    localparam int PAT_CORNER = 3;

    typedef struct {
        int frame;
        int count;
        int detected;
        int cx;
        int cy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t expQ[$];
    exp_t monExp;
    int   nChecks = 0;
    int   nPass   = 0;
    int   lat;

    always #5 clk = ~clk;

    motion_centroid_if bus ();

    motion_centroid #(
        .P_IMG_W (W),
        .P_IMG_H (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " result_valid"}, int'(bus.result_valid), 0);
        checkOutput({tag, " motion_detected"}, int'(bus.motion_detected), 0);
        checkOutput({tag, " motion_count"}, int'(bus.motion_count), 0);
        checkOutput({tag, " cent_x"}, int'(bus.cent_x), 0);
        checkOutput({tag, " cent_y"}, int'(bus.cent_y), 0);
        checkOutput({tag, " busy"}, int'(bus.busy), 0);
        checkOutput({tag, " overrun"}, int'(bus.overrun), 0);
    endtask

    function automatic logic [7:0] pixVal(input int pat, input int x, input int y);
        case (pat)
            PAT_100: return 8'd100;
            PAT_BOX: return (x >= 40 && x <= 49 && y >= 20 && y <= 29) ? 8'd200 : 8'd0;
            PAT_CORNER: begin
                if (x == 0 && y == 0)         return 8'd30;
                if (x == W - 1 && y == H - 1) return 8'd31;
                return 8'd0;
            end
            default: return 8'd0;
        endcase
    endfunction

    task automatic expectResult(input int frame, input int count, input int det,
                                input int cx, input int cy);
        exp_t e;
        e.frame    = frame;
        e.count    = count;
        e.detected = det;
        e.cx       = cx;
        e.cy       = cy;
        expQ.push_back(e);
    endtask

    // Streams nPix raster pixels, frame_start on the first, optional random idle gaps.
    task automatic applyStimulus(input int pat, input bit gaps, input int nPix);
        for (int i = 0; i < nPix; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                bus.pix_valid   = 1'b0;
                bus.frame_start = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.pix_valid   = 1'b1;
            bus.frame_start = (i == 0);
            bus.pix_gray    = pixVal(pat, i % W, i / W);
            @(posedge clk);
            #1;
            bus.pix_valid   = 1'b0;
            bus.frame_start = 1'b0;
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.result_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected result_valid", 1, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput($sformatf("frame%0d motion_count", monExp.frame),
                            int'(bus.motion_count), monExp.count);
                checkOutput($sformatf("frame%0d motion_detected", monExp.frame),
                            int'(bus.motion_detected), monExp.detected);
                checkOutput($sformatf("frame%0d cent_x", monExp.frame),
                            int'(bus.cent_x), monExp.cx);
                checkOutput($sformatf("frame%0d cent_y", monExp.frame),
                            int'(bus.cent_y), monExp.cy);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_gray    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Static scene: first frame only primes, second reports no motion.
        applyStimulus(PAT_100, 1'b0, NPIX);
        expectResult(2, 0, 0, 0, 0);
        applyStimulus(PAT_100, 1'b0, NPIX);

        // Whole frame changes 100->0: mean x 31.5, mean y 19.5, truncated.
        expectResult(3, NPIX, 1, 31, 19);
        applyStimulus(PAT_0, 1'b0, NPIX);
        expectResult(4, 100, 1, 44, 24);
        applyStimulus(PAT_BOX, 1'b0, NPIX);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                lat = k;
                break;
            end
        end
        checkOutput("frame4 result latency", lat, 24);

        // Box disappears, then corner pixels differing by exactly 30 and 31.
        expectResult(5, 100, 1, 44, 24);
        applyStimulus(PAT_0, 1'b0, NPIX);
        expectResult(6, 1, 1, W - 1, H - 1);
        applyStimulus(PAT_CORNER, 1'b0, NPIX);

        // Same scenes with random pix_valid gaps.
        expectResult(7, 1, 1, W - 1, H - 1);
        applyStimulus(PAT_0, 1'b1, NPIX);
        expectResult(8, 100, 1, 44, 24);
        applyStimulus(PAT_BOX, 1'b1, NPIX);
        expectResult(9, 100, 1, 44, 24);
        applyStimulus(PAT_0, 1'b1, NPIX);

        // Resync after 1000 pixels: partial and reload frames stay silent.
        expectResult(10, 100, 1, 44, 24);
        applyStimulus(PAT_BOX, 1'b0, NPIX);
        applyStimulus(PAT_0, 1'b0, 1000);
        applyStimulus(PAT_0, 1'b0, NPIX);
        expectResult(13, 100, 1, 44, 24);
        applyStimulus(PAT_BOX, 1'b0, NPIX);

        // Reset ten cycles into the divide aborts that frame's result.
        expectResult(14, 100, 1, 44, 24);
        applyStimulus(PAT_0, 1'b0, NPIX);
        applyStimulus(PAT_BOX, 1'b0, NPIX);
        repeat (11) @(posedge clk);
        #1;
        checkOutput("busy during divide", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        checkAllZero("mid-divide reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("after abort motion_count", int'(bus.motion_count), 0);
        checkOutput("after abort cent_x", int'(bus.cent_x), 0);
        applyStimulus(PAT_0, 1'b0, NPIX);
        expectResult(17, 100, 1, 44, 24);
        applyStimulus(PAT_BOX, 1'b0, NPIX);

        repeat (40) @(negedge clk);
        checkOutput("results still outstanding", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
